// File: rtl/count_sweep_ctrl_pkg.sv
// rtl/count_sweep_ctrl_pkg.sv - shared encodings for the count sweep sequencer
package count_sweep_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] mode_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam mode_t MODE_UP   = 2'b00;
    localparam mode_t MODE_DOWN = 2'b01;
    localparam mode_t MODE_PP   = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Encoding 11 has no meaning of its own and behaves as an up sweep.
    function automatic mode_t norm_mode(input mode_t m);
        return (m == MODE_DOWN || m == MODE_PP) ? m : MODE_UP;
    endfunction

endpackage

// File: rtl/count_sweep_ctrl_if.sv
// rtl/count_sweep_ctrl_if.sv - command and status bundle between a command source and the sweep sequencer
interface count_sweep_ctrl_if
    import count_sweep_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int R = 4
);
    logic         tick;
    logic         start;
    logic         abort;
    mode_t        mode;
    logic [N-1:0] start_val;
    logic [N-1:0] end_val;
    logic [R-1:0] repeats;
    logic [N-1:0] value;
    logic         dir;
    logic         busy;
    logic         done;
    logic [R-1:0] pass_cnt;

    modport master (
        output tick, start, abort, mode, start_val, end_val, repeats,
        input  value, dir, busy, done, pass_cnt
    );

    modport slave (
        input  tick, start, abort, mode, start_val, end_val, repeats,
        output value, dir, busy, done, pass_cnt
    );
endinterface

// File: rtl/count_sweep_ctrl_counter.sv
// rtl/count_sweep_ctrl_counter.sv - parameterised up/down loadable counter with terminal-value flag
module count_sweep_ctrl_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clk_en_i,
    input  logic         en_i,
    input  logic         direction_i,
    input  logic [N-1:0] upper_bound_i,
    input  logic [N-1:0] par_load_i,
    output logic [N-1:0] w_o,
    output logic         co_o
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] w_q, w_d;

    always_comb begin
        w_d = w_q;
        if (clk_en_i) begin
            if (load_i) begin
                w_d = par_load_i;
            end else if (en_i) begin
                w_d = direction_i ? w_q + ONE : w_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    assign w_o  = w_q;
    assign co_o = (w_q == upper_bound_i);
endmodule

// File: rtl/count_sweep_ctrl.sv
// rtl/count_sweep_ctrl.sv - sweep sequencer driving one up/down loadable counter between two endpoints
module count_sweep_ctrl
    import count_sweep_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic              clk,
    input  logic              reset,
    count_sweep_ctrl_if.slave bus
);
    state_t       state_q, state_d;
    mode_t        mode_q, mode_d;
    logic [N-1:0] start_q, start_d, end_q, end_d;
    logic [R-1:0] repeats_q, repeats_d, pass_q, pass_d;
    logic         dir_q, dir_d, tgt_end_q, tgt_end_d;
    logic         busy_q, done_q;

    logic         cnt_load, cnt_clk_en, cnt_en, cnt_co, pass_end;
    logic [N-1:0] cnt_w, target;
    logic [R-1:0] pass_next;

    assign target     = tgt_end_q ? end_q : start_q;
    assign pass_next  = pass_q + R'(1);
    assign pass_end   = (state_q == ST_RUN) && bus.tick && cnt_co && !bus.abort;
    // abort freezes the counter in whatever state it arrives, so value holds.
    assign cnt_load   = (state_q == ST_LOAD) && !bus.abort;
    assign cnt_clk_en = (state_q == ST_LOAD) || ((state_q == ST_RUN) && bus.tick);
    assign cnt_en     = (state_q == ST_RUN) && !cnt_co && !bus.abort;

    count_sweep_ctrl_counter #(.N(N)) u_counter (
        .clk          (clk),
        .rst          (reset),
        .load_i       (cnt_load),
        .clk_en_i     (cnt_clk_en),
        .en_i         (cnt_en),
        .direction_i  (dir_q),
        .upper_bound_i(target),
        .par_load_i   (start_q),
        .w_o          (cnt_w),
        .co_o         (cnt_co)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        start_d   = start_q;
        end_d     = end_q;
        repeats_d = repeats_q;
        pass_d    = pass_q;
        dir_d     = dir_q;
        tgt_end_d = tgt_end_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_LOAD;
                    mode_d    = norm_mode(bus.mode);
                    start_d   = bus.start_val;
                    end_d     = bus.end_val;
                    repeats_d = bus.repeats;
                    pass_d    = '0;
                    tgt_end_d = 1'b1;
                    dir_d     = (norm_mode(bus.mode) == MODE_DOWN) ? DIR_DOWN : DIR_UP;
                end
            end
            ST_LOAD: state_d = bus.abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (pass_end) begin
                    pass_d = pass_next;
                    if (repeats_q != '0 && pass_next == repeats_q) begin
                        state_d = ST_DONE;
                    end else if (mode_q == MODE_PP) begin
                        dir_d     = ~dir_q;
                        tgt_end_d = ~tgt_end_q;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_UP;
            start_q   <= '0;
            end_q     <= '0;
            repeats_q <= '0;
            pass_q    <= '0;
            dir_q     <= DIR_UP;
            tgt_end_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            start_q   <= start_d;
            end_q     <= end_d;
            repeats_q <= repeats_d;
            pass_q    <= pass_d;
            dir_q     <= dir_d;
            tgt_end_q <= tgt_end_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign bus.value    = cnt_w;
    assign bus.dir      = dir_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass_cnt = pass_q;
endmodule

// File: tb/tb_count_sweep_ctrl.sv
// tb/tb_count_sweep_ctrl.sv - randomized scoreboard bench for count_sweep_ctrl
module tb_count_sweep_ctrl;
    typedef struct {
        logic [3:0] value;
        logic       dir;
        logic       busy;
        logic       done;
        logic [3:0] pass;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    count_sweep_ctrl_if #(.N(4), .R(4)) bus ();
    count_sweep_ctrl #(.N(4), .R(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    exp_t       mon_e;
    bit         tick_pat[0:1023];
    int         n_pass = 0;
    int         n_total = 0;
    int         push_cnt, push_max;
    logic [3:0] last_value = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("value", int'(bus.value), int'(mon_e.value));
            check("dir", int'(bus.dir), int'(mon_e.dir));
            check("busy", int'(bus.busy), int'(mon_e.busy));
            check("done", int'(bus.done), int'(mon_e.done));
            check("pass_cnt", int'(bus.pass_cnt), int'(mon_e.pass));
        end
    end

    task automatic push(input logic [3:0] v, input logic d, input logic b, input logic dn, input logic [3:0] p);
        exp_t e;
        if (push_cnt < push_max) begin
            e.value = v; e.dir = d; e.busy = b; e.done = dn; e.pass = p;
            exp_q.push_back(e);
            push_cnt++;
        end
    endtask

    // Expected trace from the launch edge on: a run is a list of passes, each a walk
    // from one endpoint to the other modulo 16, consuming one tick per step.
    task automatic build(input logic [1:0] mode, input logic [3:0] sv, input logic [3:0] ev,
                         input logic [3:0] reps, input int abort_pass, output int abort_cyc);
        logic [3:0] from, to, v, steps, k, pass;
        logic       d;
        bit         pp, fin;
        int         j, npass;
        pp = (mode == 2'b10);
        d = (mode != 2'b01);
        from = sv; to = ev; v = sv; pass = 4'd0; npass = 0; j = 1; abort_cyc = -1; fin = 0;
        push(last_value, d, 1'b1, 1'b0, 4'd0);
        while (!fin) begin
            steps = d ? to - from : from - to;
            k = 4'd0;
            forever begin
                v = d ? from + k : from - k;
                push(v, d, 1'b1, 1'b0, pass);
                j++;
                if (j >= 1000) begin fin = 1; break; end
                if (tick_pat[j-1]) begin
                    if (k == steps) break;
                    k++;
                end
            end
            if (fin) break;
            pass++;
            npass++;
            if (abort_pass > 0 && npass == abort_pass) begin
                if (pp) d = ~d;
                push(v, d, 1'b1, 1'b0, pass);
                abort_cyc = j;
                push(v, d, 1'b0, 1'b0, pass);
                fin = 1;
            end else if (reps != 4'd0 && pass == reps) begin
                push(v, d, 1'b1, 1'b1, pass);
                push(v, d, 1'b0, 1'b0, pass);
                fin = 1;
            end else if (pp) begin
                d = ~d;
                {from, to} = {to, from};
            end else begin
                push(v, d, 1'b1, 1'b0, pass);
                j++;
            end
        end
        last_value = v;
    endtask

    task automatic fill_ticks(input int kind);
        for (int j = 0; j < 1024; j++) begin
            case (kind)
                0: tick_pat[j] = 1'b1;
                1: tick_pat[j] = (j % 3 == 1);
                default: tick_pat[j] = ($urandom_range(0, 2) != 0) || (j % 4 == 0);
            endcase
        end
    endtask

    task automatic run(input logic [1:0] mode, input logic [3:0] sv, input logic [3:0] ev,
                       input logic [3:0] reps, input int abort_pass, input int max_obs, input bit co_abort);
        int abort_cyc, len;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = mode; bus.start_val = sv; bus.end_val = ev;
        bus.repeats = reps; bus.abort = co_abort; bus.tick = 1'($urandom);
        @(posedge clk); #1;
        push_cnt = 0;
        push_max = max_obs;
        build(mode, sv, ev, reps, abort_pass, abort_cyc);
        len = push_cnt;
        for (int j = 0; j < len; j++) begin
            bus.tick = tick_pat[j];
            bus.abort = (j == abort_cyc);
            if (j < len - 1) begin
                bus.start = 1'($urandom);
                bus.mode = 2'($urandom);
                bus.start_val = 4'($urandom);
                bus.end_val = 4'($urandom);
                bus.repeats = 4'($urandom);
                @(posedge clk); #1;
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk); #1;
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [1:0] m;
        reset = 1'b1;
        bus.tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'b00;
        bus.start_val = 4'd0; bus.end_val = 4'd0; bus.repeats = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", int'(bus.value), 0);
        check("rst_dir", int'(bus.dir), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_pass", int'(bus.pass_cnt), 0);
        reset = 1'b0;

        fill_ticks(0);
        run(2'b00, 4'd3, 4'd6, 4'd1, 0, 100000, 1'b0);
        run(2'b01, 4'd1, 4'd14, 4'd2, 0, 100000, 1'b0);
        run(2'b10, 4'd2, 4'd4, 4'd3, 0, 100000, 1'b1);
        fill_ticks(1);
        run(2'b00, 4'd0, 4'd2, 4'd1, 0, 100000, 1'b0);
        fill_ticks(0);
        run(2'b10, 4'd2, 4'd5, 4'd0, 5, 100000, 1'b0);
        run(2'b10, 4'd2, 4'd5, 4'd1, 0, 100000, 1'b0);

        run(2'b00, 4'd5, 4'd12, 4'd1, 0, 6, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("arst_value", int'(bus.value), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_dir", int'(bus.dir), 1);
        check("arst_pass", int'(bus.pass_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_value = 4'd0;

        run(2'b00, 4'd7, 4'd7, 4'd2, 0, 100000, 1'b0);
        run(2'b11, 4'd14, 4'd1, 4'd1, 0, 100000, 1'b0);
        run(2'b00, 4'd1, 4'd2, 4'd0, 18, 100000, 1'b0);

        for (int r = 0; r < 10; r++) begin
            fill_ticks(2);
            m = 2'($urandom);
            if (r % 4 == 3)
                run(m, 4'($urandom), 4'($urandom), 4'd0, $urandom_range(1, 4), 100000, 1'($urandom));
            else
                run(m, 4'($urandom), 4'($urandom), 4'($urandom_range(1, 3)), 0, 100000, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/count_sweep_ctrl.md
Name: count_sweep_ctrl

Overview:
Sequencer that owns one instance of the team's parameterised up/down loadable counter and drives its load, clkEN, en, direction and upper_bound inputs. It runs programmed sweeps between two endpoints in one of three modes (up, down, ping-pong) for a programmed number of passes. It reports busy, pass count and a one-cycle done pulse. It sits between a front-panel or CPU-style command source and any display or timing logic that consumes the count value.

Parameters:
N, 4, counter/endpoint width in bits
R, 4, pass-counter and repeats width in bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
tick  in  1  count-enable strobe; counter steps only on cycles with tick=1
start  in  1  launch command; sampled only in IDLE
abort  in  1  stop request; effective in any non-IDLE state
mode  in  2  00 up, 01 down, 10 ping-pong, 11 treated as up
start_val  in  N  first endpoint, loaded at launch
end_val  in  N  second endpoint (terminal value of the first sweep)
repeats  in  R  passes to run; 0 = run continuously until abort
value  out  N  current counter value (counter W output)
dir  out  1  current direction, 1=up
busy  out  1  high in LOAD/RUN/DONE
done  out  1  one-cycle pulse on normal completion
pass_cnt  out  R  completed passes in the current run

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, value=0, dir=1, busy=0, done=0, pass_cnt=0.
- States are IDLE, LOAD, RUN, DONE. busy and done are registered from the state.
- IDLE -> LOAD when start=1:
  - latch mode, start_val, end_val and repeats; clear pass_cnt.
  - dir = 0 for down mode, 1 otherwise.
  - Input changes after launch are ignored.
- LOAD (1 cycle, independent of tick):
  - drive load=1, clkEN=1, par_load=start_val; counter holds start_val at the end of the cycle.
  - -> RUN.
- RUN:
  - drive en=1, clkEN=tick, direction=dir, upper_bound=target.
  - target = end_val in the first sweep; ping-pong alternates the target between end_val and start_val.
- Pass end: a cycle in RUN with tick=1 and co=1 (value==target).
  - On that cycle the counter must NOT step; gate en low.
  - pass_cnt increments.
- After a pass end:
  - if repeats!=0 and the new pass_cnt==repeats -> DONE.
  - otherwise, up/down mode -> LOAD (reload start_val).
  - otherwise, ping-pong: toggle dir, swap target, stay in RUN with no reload.
- Wrap-around: the counter wraps modulo 2^N in both directions. Sweeps cross 0/2^N-1 freely until target is reached.
- start_val==end_val: each pass ends on the first tick in RUN (zero steps).
- repeats=0: runs indefinitely; pass_cnt wraps modulo 2^R; done never asserts.
- DONE: done=1 for exactly one cycle; value holds; -> IDLE.
- abort (priority over pass end) in LOAD/RUN/DONE:
  - -> IDLE next cycle; done stays 0; value and pass_cnt hold.
  - abort in IDLE is ignored.
- start asserted while not IDLE is ignored. start and abort together in IDLE: start wins.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Latency: start at cycle 0 -> LOAD at cycle 1 -> value=start_val and RUN at cycle 2.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, LOAD, RUN, DONE);
  - mode encodings (MODE_UP, MODE_DOWN, MODE_PP);
  - the DIR_UP/DIR_DOWN constants.
- One sub-module: the existing counter, instantiated with N. Its co output is the pass-end detector.
- The FSM, pass counter and target mux live in count_sweep_ctrl.

Test Plan:
1. N=4, mode=00, start_val=3, end_val=6, repeats=1, tick=1 constantly, start at c0 -> value 3,4,5,6 on c2..c5; done=1 at c6 only; busy high c1..c6, low c7; pass_cnt=1.
2. mode=01, start_val=1, end_val=14, repeats=2 -> sequence 1,0,15,14, reload, 1,0,15,14; done once after the second 14; pass_cnt=2.
3. mode=10, start_val=2, end_val=4, repeats=3 -> 2,3,4,3,2,3,4 with no reload cycles; dir toggles at each endpoint; done after the final 4.
4. tick high every 3rd cycle, mode=00, 0->2, repeats=1 -> value changes only on tick cycles; LOAD still takes exactly one cycle; done follows the pass-end tick by one cycle.
5. repeats=0 ping-pong, abort after 5 passes -> IDLE next cycle; done never pulses; value and pass_cnt=5 hold; a subsequent start relaunches from start_val.
6. reset asserted asynchronously mid-RUN (value=9) -> value=0, busy=0, done=0, dir=1 immediately. Also check start_val==end_val=7 with repeats=2 -> two passes, value stays 7, done pulses.
